// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-client arbiter sharing one single-read/single-write register file
// Build option ARB_RR_EN: round-robin tie-break; undefined gives fixed priority to client 0.
module regfile_arbiter #(
  parameter int size  = 5,
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN_req0,
  input  logic [size-1:0]  req0_addr,
  input  logic [width-1:0] req0_data,
  input  logic             req0_wr,
  output logic             RDY_req0,
  input  logic             EN_req1,
  input  logic [size-1:0]  req1_addr,
  input  logic [width-1:0] req1_data,
  input  logic             req1_wr,
  output logic             RDY_req1,
  input  logic             EN_resp0,
  output logic [width-1:0] resp0,
  output logic             RDY_resp0,
  input  logic             EN_resp1,
  output logic [width-1:0] resp1,
  output logic             RDY_resp1,
  output logic [size-1:0]  rf_sub_x,
  output logic             EN_rf_sub,
  input  logic [width-1:0] rf_sub,
  output logic [size-1:0]  rf_upd_x,
  output logic [width-1:0] rf_upd_y,
  output logic             EN_rf_upd
);

  logic             reqv0, reqv1, reqw0, reqw1;
  logic [size-1:0]  reqa0, reqa1;
  logic [width-1:0] reqd0, reqd1;
  logic             respv0, respv1;
  logic [width-1:0] respd0, respd1;
  logic             elig0, elig1, gnt0, gnt1;

  assign RDY_req0  = !reqv0;
  assign RDY_req1  = !reqv1;
  assign RDY_resp0 = respv0;
  assign RDY_resp1 = respv1;
  assign resp0     = respd0;
  assign resp1     = respd1;

  // A read may only be granted once its response slot is free; writes never wait.
  assign elig0 = reqv0 && (reqw0 || !respv0);
  assign elig1 = reqv1 && (reqw1 || !respv1);

`ifdef ARB_RR_EN
  logic lp;

  assign gnt1 = elig1 && (!elig0 || !lp);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lp <= 1'b1;
    end else if (gnt0) begin
      lp <= 1'b0;
    end else if (gnt1) begin
      lp <= 1'b1;
    end
  end
`else
  assign gnt1 = elig1 && !elig0;
`endif

  assign gnt0 = elig0 && !gnt1;

  always_comb begin
    EN_rf_sub = 1'b0;
    EN_rf_upd = 1'b0;
    rf_sub_x  = '0;
    rf_upd_x  = '0;
    rf_upd_y  = '0;
    if (gnt0) begin
      if (reqw0) begin
        EN_rf_upd = 1'b1;
        rf_upd_x  = reqa0;
        rf_upd_y  = reqd0;
      end else begin
        EN_rf_sub = 1'b1;
        rf_sub_x  = reqa0;
      end
    end else if (gnt1) begin
      if (reqw1) begin
        EN_rf_upd = 1'b1;
        rf_upd_x  = reqa1;
        rf_upd_y  = reqd1;
      end else begin
        EN_rf_sub = 1'b1;
        rf_sub_x  = reqa1;
      end
    end
  end

  // Request buffers: a grant always finds the buffer full, so it can never race a load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reqv0 <= 1'b0;
      reqw0 <= 1'b0;
      reqa0 <= '0;
      reqd0 <= '0;
    end else if (gnt0) begin
      reqv0 <= 1'b0;
    end else if (EN_req0 && !reqv0) begin
      reqv0 <= 1'b1;
      reqw0 <= req0_wr;
      reqa0 <= req0_addr;
      reqd0 <= req0_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reqv1 <= 1'b0;
      reqw1 <= 1'b0;
      reqa1 <= '0;
      reqd1 <= '0;
    end else if (gnt1) begin
      reqv1 <= 1'b0;
    end else if (EN_req1 && !reqv1) begin
      reqv1 <= 1'b1;
      reqw1 <= req1_wr;
      reqa1 <= req1_addr;
      reqd1 <= req1_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      respv0 <= 1'b0;
      respd0 <= '0;
    end else if (gnt0 && !reqw0) begin
      respv0 <= 1'b1;
      respd0 <= rf_sub;
    end else if (EN_resp0 && respv0) begin
      respv0 <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      respv1 <= 1'b0;
      respd1 <= '0;
    end else if (gnt1 && !reqw1) begin
      respv1 <= 1'b1;
      respd1 <= rf_sub;
    end else if (EN_resp1 && respv1) begin
      respv1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed and randomized checks of regfile_arbiter against a transaction model
module tb_regfile_arbiter;
  localparam int SZ = 5;
  localparam int W  = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [1:0]    en_req, req_wr, en_resp;
  logic [SZ-1:0] req_addr [2];
  logic [W-1:0]  req_data [2];
  wire  [1:0]    rdy_req, rdy_resp;
  wire  [W-1:0]  resp0, resp1;
  wire  [SZ-1:0] sub_x, upd_x;
  wire  [W-1:0]  upd_y;
  wire           en_sub, en_upd;
  logic [W-1:0]  rf_mem [32];
  logic [W-1:0]  ref_mem [32];
  wire  [W-1:0]  rf_sub_data = rf_mem[sub_x];
  int            checks = 0;
  int            errors = 0;

  regfile_arbiter #(.size(SZ), .width(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_req0(en_req[0]), .req0_addr(req_addr[0]), .req0_data(req_data[0]), .req0_wr(req_wr[0]),
    .RDY_req0(rdy_req[0]),
    .EN_req1(en_req[1]), .req1_addr(req_addr[1]), .req1_data(req_data[1]), .req1_wr(req_wr[1]),
    .RDY_req1(rdy_req[1]),
    .EN_resp0(en_resp[0]), .resp0(resp0), .RDY_resp0(rdy_resp[0]),
    .EN_resp1(en_resp[1]), .resp1(resp1), .RDY_resp1(rdy_resp[1]),
    .rf_sub_x(sub_x), .EN_rf_sub(en_sub), .rf_sub(rf_sub_data),
    .rf_upd_x(upd_x), .rf_upd_y(upd_y), .EN_rf_upd(en_upd)
  );

  always #5 CLK = ~CLK;

  // Behavioural register file attached to the arbiter
  always @(posedge CLK) begin
    if (en_upd) rf_mem[upd_x] <= upd_y;
  end

  function automatic logic [W-1:0] init_word(int a);
    logic [31:0] v;
    v = 32'hA500_0000 ^ (a * 32'h0001_0203);
    return v;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    en_req  = 2'b00;
    en_resp = 2'b00;
    req_wr  = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (rdy_req !== 2'b11) begin errors++; $display("FAIL reset_rdy_req: got %b want 11", rdy_req); end
    checks++; if (rdy_resp !== 2'b00) begin errors++; $display("FAIL reset_rdy_resp: got %b want 00", rdy_resp); end
    checks++; if ({en_sub, en_upd} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {en_sub, en_upd}); end
    checks++; if (resp0 !== '0 || resp1 !== '0) begin errors++; $display("FAIL reset_resp: got %h/%h want 0/0", resp0, resp1); end
    cyc();
    RST_N = 1'b1;
    en_req = 2'b11; req_addr[0] = 5'd1; req_addr[1] = 5'd2;
    cyc();
    idle_inputs();
    checks++; if (en_sub !== 1'b1 || sub_x !== 5'd1) begin errors++; $display("FAIL pre_reset_grant: got en=%b x=%0d want en=1 x=1", en_sub, sub_x); end
    #3;
    RST_N = 1'b0;
    #1;
    checks++; if (rdy_req !== 2'b11 || rdy_resp !== 2'b00) begin errors++; $display("FAIL midreset_rdy: got req=%b resp=%b want 11/00", rdy_req, rdy_resp); end
    checks++; if ({en_sub, en_upd} !== 2'b00) begin errors++; $display("FAIL midreset_strobes: got %b want 00", {en_sub, en_upd}); end
    cyc();
    checks++; if ({en_sub, en_upd} !== 2'b00) begin errors++; $display("FAIL inreset_strobes: got %b want 00", {en_sub, en_upd}); end
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({en_sub, en_upd} !== 2'b00 || rdy_req !== 2'b11 || rdy_resp !== 2'b00) begin
        errors++; $display("FAIL lost_requests: got strobes=%b req=%b resp=%b want 00/11/00", {en_sub, en_upd}, rdy_req, rdy_resp);
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    en_req = 2'b01; req_wr = 2'b01; req_addr[0] = 5'd3; req_data[0] = 32'hDEAD_BEEF;
    cyc();
    idle_inputs();
    checks++; if (en_upd !== 1'b1 || upd_x !== 5'd3 || upd_y !== 32'hDEAD_BEEF || en_sub !== 1'b0) begin
      errors++; $display("FAIL wr_grant: got en=%b x=%0d y=%h want en=1 x=3 y=deadbeef", en_upd, upd_x, upd_y);
    end
    checks++; if (rdy_req[0] !== 1'b0) begin errors++; $display("FAIL wr_rdy_busy: got %b want 0", rdy_req[0]); end
    ref_mem[3] = 32'hDEAD_BEEF;
    cyc();
    checks++; if (rdy_req[0] !== 1'b1 || en_upd !== 1'b0) begin errors++; $display("FAIL wr_done: got rdy=%b en=%b want 1/0", rdy_req[0], en_upd); end
    en_req = 2'b01; req_addr[0] = 5'd3;
    cyc();
    idle_inputs();
    checks++; if (en_sub !== 1'b1 || sub_x !== 5'd3 || rdy_resp[0] !== 1'b0) begin
      errors++; $display("FAIL rd_grant: got en=%b x=%0d rv=%b want 1/3/0", en_sub, sub_x, rdy_resp[0]);
    end
    cyc();
    checks++; if (rdy_resp[0] !== 1'b1 || resp0 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_resp: got rv=%b d=%h want 1/deadbeef", rdy_resp[0], resp0);
    end
    en_resp[0] = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (rdy_resp[0] !== 1'b0) begin errors++; $display("FAIL rd_dequeue: got %b want 0", rdy_resp[0]); end
  endtask

  task automatic test_tie_break();
    logic [SZ-1:0] exp_x;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      en_req = 2'b11; req_wr = 2'b00;
      req_addr[0] = SZ'(r); req_addr[1] = SZ'(r + 16);
      cyc();
      idle_inputs();
      checks++; if (en_sub !== 1'b1 || sub_x !== SZ'(r)) begin errors++; $display("FAIL tie_first r%0d: got en=%b x=%0d want 1/%0d", r, en_sub, sub_x, r); end
      cyc();
      checks++; if (en_sub !== 1'b1 || sub_x !== SZ'(r + 16) || rdy_resp !== 2'b01 || resp0 !== ref_mem[r]) begin
        errors++; $display("FAIL tie_second r%0d: got en=%b x=%0d rv=%b d=%h want 1/%0d/01/%h", r, en_sub, sub_x, rdy_resp, resp0, r + 16, ref_mem[r]);
      end
      en_resp[0] = 1'b1;
      cyc();
      idle_inputs();
      checks++; if (rdy_resp !== 2'b10 || resp1 !== ref_mem[r + 16]) begin
        errors++; $display("FAIL tie_resp1 r%0d: got rv=%b d=%h want 10/%h", r, rdy_resp, resp1, ref_mem[r + 16]);
      end
      en_resp[1] = 1'b1;
      cyc();
      idle_inputs();
    end
    do_reset();
    en_req = 2'b01; req_addr[0] = 5'd5;
    cyc();
    idle_inputs();
    cyc();
    en_resp[0] = 1'b1;
    cyc();
    idle_inputs();
    en_req = 2'b11; req_addr[0] = 5'd6; req_addr[1] = 5'd7;
    cyc();
    idle_inputs();
`ifdef ARB_RR_EN
    exp_x = 5'd7;
`else
    exp_x = 5'd6;
`endif
    checks++; if (en_sub !== 1'b1 || sub_x !== exp_x) begin errors++; $display("FAIL tie_after_solo: got en=%b x=%0d want 1/%0d", en_sub, sub_x, exp_x); end
  endtask

  task automatic test_backpressure();
    do_reset();
    en_req = 2'b10; req_addr[1] = 5'd7;
    cyc();
    idle_inputs();
    cyc();
    checks++; if (rdy_resp[1] !== 1'b1 || resp1 !== ref_mem[7]) begin errors++; $display("FAIL bp_first: got rv=%b d=%h want 1/%h", rdy_resp[1], resp1, ref_mem[7]); end
    en_req = 2'b10; req_addr[1] = 5'd9;
    cyc();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++; if (en_sub !== 1'b0 || rdy_req[1] !== 1'b0 || rdy_resp[1] !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got en=%b rq=%b rv=%b want 0/0/1", i, en_sub, rdy_req[1], rdy_resp[1]);
      end
      if (i == 0) cyc();
    end
    en_resp[1] = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (en_sub !== 1'b1 || sub_x !== 5'd9 || rdy_resp[1] !== 1'b0) begin
      errors++; $display("FAIL bp_release: got en=%b x=%0d rv=%b want 1/9/0", en_sub, sub_x, rdy_resp[1]);
    end
    cyc();
    checks++; if (rdy_resp[1] !== 1'b1 || resp1 !== ref_mem[9]) begin errors++; $display("FAIL bp_second: got rv=%b d=%h want 1/%h", rdy_resp[1], resp1, ref_mem[9]); end
  endtask

  task automatic test_write_bypass();
    do_reset();
    en_req = 2'b10; req_addr[1] = 5'd5;
    cyc();
    idle_inputs();
    cyc();
    en_req = 2'b10; req_wr = 2'b10; req_addr[1] = 5'd6; req_data[1] = 32'h1234_5678;
    cyc();
    idle_inputs();
    checks++; if (en_upd !== 1'b1 || upd_x !== 5'd6 || upd_y !== 32'h1234_5678 || en_sub !== 1'b0 || rdy_resp[1] !== 1'b1) begin
      errors++; $display("FAIL wr_bypass: got en=%b x=%0d y=%h rv=%b want 1/6/12345678/1", en_upd, upd_x, upd_y, rdy_resp[1]);
    end
    ref_mem[6] = 32'h1234_5678;
  endtask

  task automatic test_protocol_violation();
    do_reset();
    en_req = 2'b01; req_addr[0] = 5'd2;
    cyc();
    idle_inputs();
    cyc();
    en_req = 2'b01; req_addr[0] = 5'd4;
    cyc();
    idle_inputs();
    en_req = 2'b01; req_wr = 2'b01; req_addr[0] = 5'd11; req_data[0] = 32'hBAD0_BAD0;
    cyc();
    idle_inputs();
    checks++; if ({en_sub, en_upd} !== 2'b00) begin errors++; $display("FAIL viol_ignored: got strobes=%b want 00", {en_sub, en_upd}); end
    en_resp[0] = 1'b1;
    cyc();
    idle_inputs();
    checks++; if (en_sub !== 1'b1 || sub_x !== 5'd4 || en_upd !== 1'b0) begin
      errors++; $display("FAIL viol_addr: got en=%b x=%0d upd=%b want 1/4/0", en_sub, sub_x, en_upd);
    end
  endtask

  task automatic test_random(int n);
    bit            pend [2];
    bit            mwr [2];
    bit            rv [2];
    logic [SZ-1:0] ma [2];
    logic [W-1:0]  md [2];
    logic [W-1:0]  rd [2];
    bit            lp, gw, gr, e0, e1;
    int            g;
    logic [SZ-1:0] ex_sx, ex_ux;
    logic [W-1:0]  ex_uy;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; mwr[i] = 0; rv[i] = 0; ma[i] = '0; md[i] = '0; rd[i] = '0;
    end
    lp = 1;
    for (int c = 0; c < n; c++) begin
      e0 = pend[0] && (mwr[0] || !rv[0]);
      e1 = pend[1] && (mwr[1] || !rv[1]);
      g = -1;
      if (e0 && e1) begin
`ifdef ARB_RR_EN
        g = lp ? 0 : 1;
`else
        g = 0;
`endif
      end else if (e0) g = 0;
      else if (e1) g = 1;
      gw = 0; gr = 0; ex_sx = '0; ex_ux = '0; ex_uy = '0;
      if (g >= 0) begin
        gw = mwr[g]; gr = !mwr[g];
        if (gw) begin ex_ux = ma[g]; ex_uy = md[g]; end
        else ex_sx = ma[g];
      end
      checks++; if (rdy_req !== {!pend[1], !pend[0]}) begin errors++; $display("FAIL rnd_rdy_req c%0d: got %b want %b", c, rdy_req, {!pend[1], !pend[0]}); end
      checks++; if (rdy_resp !== {rv[1], rv[0]}) begin errors++; $display("FAIL rnd_rdy_resp c%0d: got %b want %b", c, rdy_resp, {rv[1], rv[0]}); end
      checks++; if (resp0 !== rd[0] || resp1 !== rd[1]) begin errors++; $display("FAIL rnd_resp c%0d: got %h/%h want %h/%h", c, resp0, resp1, rd[0], rd[1]); end
      checks++; if (en_upd !== gw || en_sub !== gr) begin errors++; $display("FAIL rnd_strobe c%0d: got upd=%b sub=%b want %b/%b", c, en_upd, en_sub, gw, gr); end
      checks++; if (sub_x !== ex_sx || upd_x !== ex_ux || upd_y !== ex_uy) begin
        errors++; $display("FAIL rnd_bus c%0d: got sx=%0d ux=%0d uy=%h want %0d/%0d/%h", c, sub_x, upd_x, upd_y, ex_sx, ex_ux, ex_uy);
      end
      for (int i = 0; i < 2; i++) begin
        en_req[i]   = 1'($urandom_range(0, 1));
        req_wr[i]   = 1'($urandom_range(0, 1));
        req_addr[i] = SZ'($urandom_range(0, 31));
        req_data[i] = $urandom();
        en_resp[i]  = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (en_req[i] && !pend[i]) begin
          pend[i] = 1; mwr[i] = req_wr[i]; ma[i] = req_addr[i]; md[i] = req_data[i];
        end else if (g == i) begin
          pend[i] = 0;
        end
        if (en_resp[i] && rv[i]) rv[i] = 0;
      end
      if (g >= 0) begin
        if (mwr[g]) ref_mem[ma[g]] = md[g];
        else begin rv[g] = 1; rd[g] = ref_mem[ma[g]]; end
        lp = (g == 1);
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    req_addr[0] = '0; req_addr[1] = '0;
    req_data[0] = '0; req_data[1] = '0;
    idle_inputs();
    RST_N = 1'b0;
    #2;
    test_reset();
    test_write_read();
    test_tie_break();
    test_backpressure();
    test_write_bypass();
    test_protocol_violation();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
